uart_rx: RTL and testbench

- UART receiver: the downstream consumer of the UART transmitter's serial line.
- Oversamples RX_IN by a runtime prescale, majority-votes each bit and checks optional parity and the stop bit.
- Delivers a parallel word with a one-cycle DATA_VALID strobe to the register-file/control side.
- Frame format: 1 start (0), WIDTH data LSB-first, optional parity, 1 stop (1).

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx_data_sampling.sv | 31 +++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing definitions: receiver FSM encoding, legal oversampling ratios, line levels.
// Pure declarations, no logic; the line-level constants are shared with the transmitter side.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Unsupported ratios fall back to x8 so a bad setting still yields a usable bit clock.
    function automatic int legal_prescale(input int p);
        if (p == PRESC_16 || p == PRESC_32) begin
            return p;
        end
        return PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bus: parallel word plus one-cycle valid / error strobes.
// Strobe-only signalling, there is no ready; the consumer must take each strobe when it occurs.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_ERR;
    logic             STP_ERR;

    modport master (output P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
    modport slave  (input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
endinterface

// File: rtl/uart_rx_data_sampling.sv
// Three-point oversampler around mid-bit with a 2-of-3 majority vote.
// Vote is valid from edge_cnt = P/2+2 of each bit; no backpressure, samples every bit period.
module data_sampling #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sampled_bit
);

    logic [PRESC_W-1:0] mid;
    logic [2:0]         smp;

    assign mid = prescale >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp <= 3'b000;
        end else begin
            if (edge_cnt == mid - PRESC_W'(1)) smp[0] <= RX_IN;
            if (edge_cnt == mid)               smp[1] <= RX_IN;
            if (edge_cnt == mid + PRESC_W'(1)) smp[2] <= RX_IN;
        end
    end

    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled framing FSM, LSB-first deserialiser, parity and stop checks.
// Strobe (2+WIDTH+PAR_EN)*P+1 cycles after start detect, +2 with UART_RX_SYNC_EN (2-flop RX_IN synchroniser).
// No backpressure: results are one-cycle strobes and the next start edge is accepted in the strobe cycle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    uart_rx_if.master          rx_out
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic               rx_s;
    state_t             state;
    logic [PRESC_W-1:0] edge_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic [PRESC_W-1:0] presc_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic               par_fail;
    logic               sampled_bit;

    logic [WIDTH-1:0]   p_data_q;
    logic               data_valid_q;
    logic               par_err_q;
    logic               stp_err_q;

    logic               bit_end;
    logic               last_bit;
    logic               take_start;
    logic               par_exp;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    data_sampling #(
        .PRESC_W (PRESC_W)
    ) u_sampling (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (rx_s),
        .edge_cnt    (edge_cnt),
        .prescale    (presc_q),
        .sampled_bit (sampled_bit)
    );

    assign bit_end  = (edge_cnt == presc_q - PRESC_W'(1));
    assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));
    assign par_exp  = (^shreg) ^ par_typ_q;

    // A line already low at the stop-bit end is the next start bit: go straight to START
    // so full-rate traffic keeps its bit alignment instead of slipping a cycle per frame.
    assign take_start = (rx_s == START_BIT) &&
                        ((state == IDLE) || ((state == STOP) && bit_end));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            presc_q      <= PRESC_W'(PRESC_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail     <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (take_start) begin
                presc_q   <= PRESC_W'(legal_prescale(int'(PRESCALE)));
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end

            if (state == IDLE || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end

            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    par_fail <= 1'b0;
                    if (take_start) state <= START;
                end

                START: begin
                    if (bit_end) begin
                        state <= (sampled_bit == START_BIT) ? DATA : IDLE;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shreg <= {sampled_bit, shreg[WIDTH-1:1]};
                        if (last_bit) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        par_fail <= (sampled_bit != par_exp);
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (sampled_bit == STOP_BIT && !par_fail) begin
                            p_data_q     <= shreg;
                            data_valid_q <= 1'b1;
                        end
                        par_err_q <= par_fail;
                        stp_err_q <= (sampled_bit != STOP_BIT);
                        par_fail  <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= take_start ? START : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx_out.P_DATA     = p_data_q;
    assign rx_out.DATA_VALID = data_valid_q;
    assign rx_out.PAR_ERR    = par_err_q;
    assign rx_out.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame stimulus with a queue scoreboard; expected outcome and strobe cycle come from frame rules.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int WIDTH   = 8;
    localparam int PRESC_W = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic               CLK      = 1'b0;
    logic               RST      = 1'b1;
    logic               RX_IN    = 1'b1;
    logic [PRESC_W-1:0] PRESCALE = 6'd8;
    logic               PAR_EN   = 1'b0;
    logic               PAR_TYP  = 1'b0;

    uart_rx_if #(.WIDTH(WIDTH)) rx_out ();

    uart_rx #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PRESCALE (PRESCALE),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .rx_out   (rx_out)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
        int         cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         dv_hist[$];
    int         n_checks  = 0;
    int         n_fail    = 0;
    logic [7:0] last_good = 8'h00;

    function automatic void check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every strobe cycle consumes one expected frame outcome.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST && (rx_out.DATA_VALID || rx_out.PAR_ERR || rx_out.STP_ERR)) begin
                if (rx_out.DATA_VALID) dv_hist.push_back(cyc);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got dv=%0b pe=%0b se=%0b, expected none (cycle %0d)",
                             rx_out.DATA_VALID, rx_out.PAR_ERR, rx_out.STP_ERR, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("data_valid",   rx_out.DATA_VALID, e.dv);
                    check("par_err",      rx_out.PAR_ERR,    e.pe);
                    check("stp_err",      rx_out.STP_ERR,    e.se);
                    check("p_data",       rx_out.P_DATA,     e.pdata);
                    check("strobe_cycle", cyc,               e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        n_fail++;
        $display("FAIL watchdog: got no completion by 900us, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = v;
        end
    endtask

    // Drives one frame; glitch inverts one cycle near the middle vote sample of bit glitch_bit;
    // abort_bit >= 0 stops mid-bit with no outcome expected.
    task automatic send_frame(input logic [5:0] presc, input logic pen, input logic ptyp,
                              input logic [7:0] data, input logic bad_par, input logic bad_stop,
                              input int glitch_bit, input int abort_bit);
        int          p;
        int          n;
        logic        v;
        logic [10:0] bits;
        exp_t        e;
        p = (presc == 6'd8 || presc == 6'd16 || presc == 6'd32) ? int'(presc) : 8;
        n = pen ? 11 : 10;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        if (pen) bits[9] = (^data) ^ ptyp ^ bad_par;
        bits[n-1] = ~bad_stop;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                @(negedge CLK);
                if (b == 0 && c == 0) begin
                    PRESCALE = presc;
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                    if (abort_bit < 0) begin
                        e.pe = pen & bad_par;
                        e.se = bad_stop;
                        e.dv = !(e.pe || e.se);
                        if (e.dv) last_good = data;
                        e.pdata = last_good;
                        e.cyc   = cyc + n * p + 1 + SYNC_LAT;
                        sb_q.push_back(e);
                    end
                end
                if (b == 1 && c == 0) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                if (b == n - 1 && c == 0) begin
                    PRESCALE = presc;
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                end
                if (b == abort_bit && c == p / 2) return;
                v = bits[b];
                if (b == glitch_bit && c == p / 2 + 1) v = ~v;
                RX_IN = v;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        check(name, sb_q.size(), 0);
    endtask

    initial begin : stim
        int         s;
        exp_t       e;
        logic [5:0] pr;
        logic       pen;
        logic       bad_par;
        int         sel;

        #2 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_p_data",     rx_out.P_DATA,     0);
        check("rst_data_valid", rx_out.DATA_VALID, 0);
        check("rst_par_err",    rx_out.PAR_ERR,    0);
        check("rst_stp_err",    rx_out.STP_ERR,    0);
        RST = 1'b1;
        drive(1'b1, 5);

        send_frame(6'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 4);
        send_frame(6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 4);
        send_frame(6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, -1, -1);
        drive(1'b1, 4);
        send_frame(6'd32, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1, -1, -1);
        drive(1'b1, 4);

        // Short low pulse: false start, no strobe expected.
        @(negedge CLK);
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        drive(1'b0, 2);
        drive(1'b1, 24);
        send_frame(6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 4);

        send_frame(6'd16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 4, -1);
        drive(1'b1, 4);
        send_frame(6'd16, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, -1, -1);
        send_frame(6'd16, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 4);
        wait_drain("drain_directed");
        if (dv_hist.size() >= 2)
            check("b2b_spacing", dv_hist[dv_hist.size()-1] - dv_hist[dv_hist.size()-2], 160);

        // Reset in the middle of a data bit.
        send_frame(6'd16, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, -1, 4);
        #1 RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        check("abort_p_data",     rx_out.P_DATA,     0);
        check("abort_data_valid", rx_out.DATA_VALID, 0);
        check("abort_par_err",    rx_out.PAR_ERR,    0);
        check("abort_stp_err",    rx_out.STP_ERR,    0);
        last_good = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        drive(1'b1, 4);
        send_frame(6'd16, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 4);

        // Break: line low for two frame times gives two stop errors, then silence.
        @(negedge CLK);
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        RX_IN    = 1'b0;
        s = cyc;
        for (int k = 1; k <= 2; k++) begin
            e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b1;
            e.pdata = last_good;
            e.cyc   = s + k * 80 + 1 + SYNC_LAT;
            sb_q.push_back(e);
        end
        drive(1'b0, 159);
        drive(1'b1, 20);
        wait_drain("drain_break");

        send_frame(6'd12, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 3);
        send_frame(6'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1, -1);
        drive(1'b1, 3);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3)      pr = 6'd8;
            else if (sel < 6) pr = 6'd16;
            else if (sel < 9) pr = 6'd32;
            else begin
                pr = 6'($urandom_range(0, 63));
                if (pr == 6'd8 || pr == 6'd16 || pr == 6'd32) pr = 6'd5;
            end
            pen     = 1'($urandom_range(0, 1));
            bad_par = pen && ($urandom_range(0, 4) == 0);
            send_frame(pr, pen, 1'($urandom_range(0, 1)), 8'($urandom), bad_par,
                       $urandom_range(0, 5) == 0,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1, -1);
            if ($urandom_range(0, 2) != 0) drive(1'b1, $urandom_range(1, 40));
        end
        drive(1'b1, 4);
        wait_drain("drain_random");
        drive(1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
